// File: rtl/medidor_faixa_uc.sv
// Control unit for the range-measuring game: periodic measurement, "XYZ#" transmission,
// target window per level and level advance on hits. Optional macro RANDOM_FAIXA_EN.
module medidor_faixa_uc #(
  parameter int NUM_NIVEIS     = 4,
  parameter int TIMEOUT_MEDIDA = 3_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        fim_time,
  input  logic        pronto_medida,
  input  logic        pronto_tx,
  input  logic        is_ultimo_char,
  input  logic        fim_3sec,
  output logic        zera,
  output logic        zera_time,
  output logic        conta_time,
  output logic        mensurar,
  output logic        partida_tx,
  output logic        zera_char,
  output logic        conta_prox_char,
  output logic [11:0] upperL,
  output logic [11:0] lowerL,
  output logic [1:0]  nivel,
  output logic        pronto,
  output logic        timeout,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    MEDE        = 4'h3,
    AGUARDA_MED = 4'h4,
    TRANSMITE   = 4'h5,
    AGUARDA_TX  = 4'h6,
    PROX_CHAR   = 4'h7,
    VERIFICA    = 4'h8,
    ACERTO      = 4'h9,
    FIM         = 4'hA
  } estado_t;

  localparam int              TMO_W        = (TIMEOUT_MEDIDA > 1) ? $clog2(TIMEOUT_MEDIDA) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX      = TMO_W'(TIMEOUT_MEDIDA - 1);
  localparam logic [1:0]       ULTIMO_NIVEL = 2'(NUM_NIVEIS - 1);

  estado_t          estado;
  estado_t          estado_d;
  logic             tmo_d;
  logic             erro_d;
  logic             acerto_pend;
  logic [TMO_W-1:0] tmo_cnt;
  logic [1:0]       indice;

  // BCD cm window per table index, packed as {upper, lower}.
  function automatic logic [23:0] janela(input logic [1:0] i);
    case (i)
      2'd0:    janela = {12'h030, 12'h010};
      2'd1:    janela = {12'h055, 12'h040};
      2'd2:    janela = {12'h028, 12'h020};
      default: janela = {12'h064, 12'h060};
    endcase
  endfunction

  assign {upperL, lowerL} = janela(indice);
  assign db_estado        = estado;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    estado_d = estado;
    tmo_d    = 1'b0;
    erro_d   = 1'b0;
    case (estado)
      INICIAL:     if (iniciar) estado_d = PREPARA;
      PREPARA:     estado_d = ESPERA;
      ESPERA:      if (fim_time) estado_d = MEDE;
      MEDE:        estado_d = AGUARDA_MED;
      AGUARDA_MED: begin
        if (pronto_medida) begin
          estado_d = TRANSMITE;
        end else if (tmo_cnt == TMO_MAX) begin
          estado_d = ESPERA;
          tmo_d    = 1'b1;
        end
      end
      TRANSMITE:   estado_d = AGUARDA_TX;
      AGUARDA_TX:  if (pronto_tx) estado_d = is_ultimo_char ? VERIFICA : PROX_CHAR;
      PROX_CHAR:   estado_d = TRANSMITE;
      VERIFICA: begin
        if (acerto_pend) begin
          estado_d = ACERTO;
        end else begin
          estado_d = ESPERA;
          erro_d   = 1'b1;
        end
      end
      ACERTO:      estado_d = (nivel == ULTIMO_NIVEL) ? FIM : ESPERA;
      FIM:         if (iniciar) estado_d = PREPARA;
      default:     estado_d = INICIAL;
    endcase
  end

  // Outputs are registered from the next state, so each strobe is aligned with its state
  // and transition strobes (timeout, miss clear) land in the first cycle of the target.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado          <= INICIAL;
      zera            <= 1'b0;
      zera_time       <= 1'b0;
      conta_time      <= 1'b0;
      mensurar        <= 1'b0;
      partida_tx      <= 1'b0;
      zera_char       <= 1'b0;
      conta_prox_char <= 1'b0;
      pronto          <= 1'b0;
      timeout         <= 1'b0;
      nivel           <= 2'd0;
      acerto_pend     <= 1'b0;
      tmo_cnt         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      estado          <= estado_d;
      zera            <= (estado_d == PREPARA);
      zera_time       <= (estado_d == PREPARA) || (estado_d == ACERTO) || tmo_d || erro_d;
      conta_time      <= (estado_d == ESPERA);
      mensurar        <= (estado_d == MEDE);
      partida_tx      <= (estado_d == TRANSMITE);
      zera_char       <= (estado_d == PREPARA) || (estado_d == VERIFICA);
      conta_prox_char <= (estado_d == PROX_CHAR);
      pronto          <= (estado_d == FIM);
      timeout         <= tmo_d;

      if (estado == MEDE) begin
        tmo_cnt <= '0;
      end else if (estado == AGUARDA_MED) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (estado == FIM && iniciar) begin
        nivel <= 2'd0;
      end else if (estado == ACERTO && nivel != ULTIMO_NIVEL) begin
        nivel <= nivel + 2'd1;
      end

      // Sticky hit: a late fim_3sec pulse survives until VERIFICA, and a set beats the clear.
      if (fim_3sec && estado != INICIAL && estado != PREPARA && estado != FIM) begin
        acerto_pend <= 1'b1;
      end else if (estado == ACERTO || estado == PREPARA) begin
        acerto_pend <= 1'b0;
      end
    end
  end

`ifdef RANDOM_FAIXA_EN
  logic [7:0] lfsr;
  logic [1:0] sorteio;

  // x^8+x^6+x^5+x^4+1, maximal length, so a nonzero seed never reaches 0x00.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr <= 8'h01;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign sorteio = (lfsr[1:0] == indice) ? indice + 2'd1 : lfsr[1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      indice <= 2'd0;
    end else if (estado == ACERTO) begin
      indice <= sorteio;
    end
  end
`else
  assign indice = nivel;
`endif

endmodule

// File: tb/tb_medidor_faixa_uc.sv
// Directed self-checking bench for medidor_faixa_uc (short measurement timeout for speed).
module tb_medidor_faixa_uc;

  localparam int TMO = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iniciar = 1'b0, fim_time = 1'b0, pronto_medida = 1'b0;
  logic        pronto_tx = 1'b0, is_ultimo_char = 1'b0, fim_3sec = 1'b0;
  logic        zera, zera_time, conta_time, mensurar, partida_tx, zera_char, conta_prox_char;
  logic [11:0] upperL, lowerL;
  logic [1:0]  nivel;
  logic        pronto, timeout;
  logic [3:0]  db_estado;

  int n_checks = 0;
  int n_fail   = 0;
  int n_tx = 0, n_pc = 0, n_zc = 0;

  medidor_faixa_uc #(.NUM_NIVEIS(4), .TIMEOUT_MEDIDA(TMO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fim_time(fim_time),
    .pronto_medida(pronto_medida), .pronto_tx(pronto_tx), .is_ultimo_char(is_ultimo_char),
    .fim_3sec(fim_3sec), .zera(zera), .zera_time(zera_time), .conta_time(conta_time),
    .mensurar(mensurar), .partida_tx(partida_tx), .zera_char(zera_char),
    .conta_prox_char(conta_prox_char), .upperL(upperL), .lowerL(lowerL), .nivel(nivel),
    .pronto(pronto), .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (partida_tx)      n_tx++;
    if (conta_prox_char) n_pc++;
    if (zera_char)       n_zc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] strobes();
    return 32'({zera, zera_time, conta_time, mensurar, partida_tx,
                zera_char, conta_prox_char, pronto, timeout});
  endfunction

  // From ESPERA: one measurement and a 4-char transmission, ending one edge after VERIFICA.
  task automatic run_round(input bit hit, input string tag);
    n_tx = 0; n_pc = 0; n_zc = 0;
    fim_time = 1'b1; tick(); fim_time = 1'b0;
    check({tag, "_mede"}, 32'(mensurar), 32'd1);
    tick();
    pronto_medida = 1'b1; tick(); pronto_medida = 1'b0;
    tick();
    if (hit) begin
      fim_3sec = 1'b1; tick(); fim_3sec = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      pronto_tx = 1'b1; is_ultimo_char = (k == 3);
      tick();
      pronto_tx = 1'b0; is_ultimo_char = 1'b0;
      if (k < 3) begin
        tick(); tick();
      end
    end
    check({tag, "_verifica"}, 32'(db_estado), 32'h8);
    tick();
  endtask

`ifdef RANDOM_FAIXA_EN
  logic [23:0] prev_win;
`endif

  initial begin
    // T1: reset state, then reset asserted mid-transmission
    repeat (3) tick();
    check("rst_estado", 32'(db_estado), 32'h0);
    check("rst_strobes", strobes(), 32'h0);
    check("rst_upper", 32'(upperL), 32'h030);
    check("rst_lower", 32'(lowerL), 32'h010);
    reset = 1'b1;
    tick();
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    check("prepara", {28'd0, db_estado}, 32'h1);
    check("prepara_zeros", 32'({zera, zera_time, zera_char}), 32'h7);
    tick();
    check("espera", 32'({db_estado, conta_time}), 32'h5);
    fim_time = 1'b1; tick(); fim_time = 1'b0;
    tick();
    pronto_medida = 1'b1; tick(); pronto_medida = 1'b0;
    tick();
    check("aguarda_tx", 32'(db_estado), 32'h6);
    reset = 1'b0;
    #1;
    check("async_rst", 32'(db_estado), 32'h0);
    tick();
    check("t1_strobes", strobes(), 32'h0);
    check("t1_nivel", 32'(nivel), 32'h0);
    check("t1_janela", 32'({upperL, lowerL}), 32'h030010);
    reset = 1'b1;
    tick();
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    tick();

    // T2: full miss round
    run_round(1'b0, "t2");
    check("t2_estado", 32'(db_estado), 32'h2);
    check("t2_zera_time", 32'(zera_time), 32'h1);
    check("t2_partida", 32'(n_tx), 32'd4);
    check("t2_prox_char", 32'(n_pc), 32'd3);
    check("t2_zera_char", 32'(n_zc), 32'd1);
    check("t2_nivel", 32'(nivel), 32'h0);

    // T3: hit flagged during AGUARDA_TX
    run_round(1'b1, "t3");
    check("t3_acerto", 32'({db_estado, zera_time}), 32'h13);
    tick();
    check("t3_espera", 32'(db_estado), 32'h2);
    check("t3_nivel", 32'(nivel), 32'h1);
`ifndef RANDOM_FAIXA_EN
    check("t3_janela", 32'({upperL, lowerL}), 32'h055040);
`endif

    // T4: measurement timeout
    fim_time = 1'b1; tick(); fim_time = 1'b0;
    tick();
    n_tx = 0;
    repeat (TMO - 1) tick();
    check("t4_antes", 32'({db_estado, timeout}), 32'h8);
    tick();
    check("t4_timeout", 32'({db_estado, timeout, zera_time}), 32'hB);
    tick();
    check("t4_pulso", 32'(timeout), 32'h0);
    check("t4_sem_tx", 32'(n_tx), 32'd0);
    check("t4_nivel", 32'(nivel), 32'h1);

    // T5: iniciar ignored while playing, then three more hits to FIM
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    check("t5_ignora", 32'(db_estado), 32'h2);
    run_round(1'b1, "t5a"); tick();
    check("t5_nivel2", 32'(nivel), 32'h2);
`ifndef RANDOM_FAIXA_EN
    check("t5_janela2", 32'({upperL, lowerL}), 32'h028020);
`endif
    run_round(1'b1, "t5b"); tick();
    check("t5_nivel3", 32'(nivel), 32'h3);
`ifndef RANDOM_FAIXA_EN
    check("t5_janela3", 32'({upperL, lowerL}), 32'h064060);
`endif
    run_round(1'b1, "t5c");
    check("t5_acerto", 32'(db_estado), 32'h9);
    tick();
    check("t5_fim", 32'({db_estado, pronto}), 32'h15);
    check("t5_fim_nivel", 32'(nivel), 32'h3);
    tick();
    check("t5_fim_fica", 32'({db_estado, pronto}), 32'h15);
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    check("t5_prepara", 32'({db_estado, zera, pronto}), 32'h6);
    check("t5_nivel0", 32'(nivel), 32'h0);
    tick();
    check("t5_espera", 32'(db_estado), 32'h2);

`ifdef RANDOM_FAIXA_EN
    // T6: every hit must move to a different window; LFSR never locks up
    for (int h = 0; h < 8; h++) begin
      prev_win = {upperL, lowerL};
      run_round(1'b1, "t6");
      tick();
      check("t6_janela_muda", 32'({upperL, lowerL} != prev_win), 32'd1);
      check("t6_lfsr", 32'(dut.lfsr != 8'h00), 32'd1);
      if (db_estado == 4'hA) begin
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        tick();
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
